// File: rtl/vadd_add_core.sv
// Add stage of the vadd pipeline: ap_ctrl_hs callee that pops LEN pairs from
// FIFOs a_V/b_V and pushes their wrapped sums to c_V at one element per cycle.
module vadd_add_core #(
   parameter int DATA_W = 32,
   parameter int LEN    = 16,
   parameter int CNT_W  = 5
) (
   input  logic              ap_clk,
   input  logic              ap_rst,
   input  logic              ap_start,
   output logic              ap_done,
   output logic              ap_idle,
   output logic              ap_ready,
   input  logic [DATA_W-1:0] a_V_dout,
   input  logic              a_V_empty_n,
   output logic              a_V_read,
   input  logic [DATA_W-1:0] b_V_dout,
   input  logic              b_V_empty_n,
   output logic              b_V_read,
   output logic [DATA_W-1:0] c_V_din,
   input  logic              c_V_full_n,
   output logic              c_V_write
);

   typedef enum logic [2:0] {
      S_IDLE = 3'b001,
      S_RUN  = 3'b010,
      S_DONE = 3'b100
   } state_t;

   localparam logic [CNT_W-1:0] LEN_C  = CNT_W'(LEN);
   localparam logic [CNT_W-1:0] LAST_C = CNT_W'(LEN - 1);

   state_t              state;
   logic [CNT_W-1:0]    rd_cnt;
   logic [CNT_W-1:0]    wr_cnt;
   logic                out_valid;
   logic [DATA_W-1:0]   out_reg;
   logic                run;
   logic                fire;
   logic                push;

   assign run = (state == S_RUN);

   // A pop is only allowed when the output register is free or drains this cycle.
   assign fire = run & a_V_empty_n & b_V_empty_n & (rd_cnt < LEN_C)
               & (~out_valid | c_V_full_n);
   assign push = run & out_valid & c_V_full_n;

   assign a_V_read  = fire;
   assign b_V_read  = fire;
   assign c_V_write = push;
   assign c_V_din   = out_reg;

   assign ap_done  = (state == S_DONE);
   assign ap_ready = (state == S_DONE);
   assign ap_idle  = (state == S_IDLE) & ~ap_start;

   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         state     <= S_IDLE;
         rd_cnt    <= '0;
         wr_cnt    <= '0;
         out_valid <= 1'b0;
         out_reg   <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (ap_start) begin
                  state     <= S_RUN;
                  rd_cnt    <= '0;
                  wr_cnt    <= '0;
                  out_valid <= 1'b0;
               end
            end
            S_RUN: begin
               if (fire) begin
                  out_reg   <= a_V_dout + b_V_dout;
                  out_valid <= 1'b1;
                  rd_cnt    <= rd_cnt + 1'b1;
               end else if (push) begin
                  out_valid <= 1'b0;
               end
               if (push) begin
                  wr_cnt <= wr_cnt + 1'b1;
                  if (wr_cnt == LAST_C)
                     state <= S_DONE;
               end
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
